// File: rtl/imem_loader_if.sv
// Word-stream input and byte-wide write port of the instruction-memory loader.
// The loader itself takes the slave view.
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic [31:0]       word_in;
  logic              word_valid;
  logic              last;
  logic              word_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  modport slave (
    input  word_in, word_valid, last,
    output word_ready, we, waddr, wdata
  );

  modport master (
    output word_in, word_valid, last,
    input  word_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: accepts 32-bit words and writes them big-endian, one byte per cycle,
// into the instruction memory while holding the pipeline in reset.
module imem_loader #(
  parameter int          DEPTH     = 512,
  parameter int          ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               R,
  input  logic               start,
  imem_loader_if.slave       bus,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               pipe_hold,
  output logic [7:0]         word_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] BASE_ALIGNED = {1'b0, ADDR_W'(BASE_ADDR & ~32'd3)};
  localparam logic [ADDR_W:0] END_ADDR     = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   addr;
  logic [ADDR_W:0]   addr_inc;
  logic [31:0]       word_reg;
  logic              last_reg;
  logic [1:0]        b;
  logic              load;

  // addr carries one extra bit so a full memory shows up as addr == DEPTH.
  assign addr_inc  = addr + (ADDR_W+1)'(1);
  assign load      = ((state == IDLE) || (state == DONE)) && start;
  assign bus.waddr = addr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    bus.word_ready = 1'b0;
    bus.we         = 1'b0;
    busy           = 1'b0;
    pipe_hold      = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        bus.word_ready = 1'b1;
        busy           = 1'b1;
        if (bus.word_valid) state_next = WRITE;
      end
      WRITE: begin
        bus.we = 1'b1;
        busy   = 1'b1;
        if (b == 2'd3) begin
          if (last_reg || (addr_inc == END_ADDR)) state_next = DONE;
          else                                    state_next = ACCEPT;
        end
      end
      DONE: begin
        pipe_hold = 1'b0;
        if (start) state_next = ACCEPT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.wdata = word_reg[31:24];
    case (b)
      2'd0: bus.wdata = word_reg[31:24];
      2'd1: bus.wdata = word_reg[23:16];
      2'd2: bus.wdata = word_reg[15:8];
      2'd3: bus.wdata = word_reg[7:0];
      default: bus.wdata = word_reg[31:24];
    endcase
  end

  // last takes priority over overflow when the final word exactly fills memory.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      addr       <= '0;
      b          <= 2'd0;
      word_count <= 8'd0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_reg   <= 32'd0;
      last_reg   <= 1'b0;
    end else begin
      if (load) begin
        addr       <= BASE_ALIGNED;
        word_count <= 8'd0;
        done       <= 1'b0;
        overflow   <= 1'b0;
      end
      if ((state == ACCEPT) && bus.word_valid) begin
        word_reg <= bus.word_in;
        last_reg <= bus.last;
        b        <= 2'd0;
      end
      if (state == WRITE) begin
        addr <= addr_inc;
        b    <= b + 2'd1;
        if (b == 2'd3) begin
          word_count <= word_count + 8'd1;
          if (last_reg) begin
            done <= 1'b1;
          end else if (addr_inc == END_ADDR) begin
            done     <= 1'b1;
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven single-word loads, hand-written corner sequences,
// and randomized streams checked against a word-level memory-image model.
module tb_imem_loader;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int BASE_B = 'h1FD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] word_in = 32'd0;
  logic        word_valid = 1'b0;
  logic        last = 1'b0;

  logic       busy_a, done_a, ovf_a, hold_a;
  logic [7:0] count_a;
  logic       busy_b, done_b, ovf_b, hold_b;
  logic [7:0] count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus_a ();
  imem_loader_if #(.ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.word_in    = word_in;
  assign bus_a.word_valid = word_valid;
  assign bus_a.last       = last;
  assign bus_b.word_in    = word_in;
  assign bus_b.word_valid = word_valid;
  assign bus_b.last       = last;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut_a (
    .clk(clk), .R(rst_n), .start(start), .bus(bus_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .pipe_hold(hold_a), .word_count(count_a)
  );

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .R(rst_n), .start(start), .bus(bus_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .pipe_hold(hold_b), .word_count(count_b)
  );

  // Captured memory images; a byte belongs to the current test when its epoch matches.
  logic [7:0] cap_a [DEPTH];
  logic [7:0] cap_b [DEPTH];
  int         ep_a [DEPTH];
  int         ep_b [DEPTH];
  int         epoch = 0;
  int         writes_a = 0, writes_b = 0, wbase_a = 0, wbase_b = 0;
  int         last_waddr_a = -1, last_waddr_b = -1;

  always @(negedge clk) begin
    if (bus_a.we) begin
      cap_a[bus_a.waddr] = bus_a.wdata;
      ep_a[bus_a.waddr]  = epoch;
      writes_a++;
      last_waddr_a = int'(bus_a.waddr);
    end
    if (bus_b.we) begin
      cap_b[bus_b.waddr] = bus_b.wdata;
      ep_b[bus_b.waddr]  = epoch;
      writes_b++;
      last_waddr_b = int'(bus_b.waddr);
    end
  end

  logic [31:0] words[$];
  bit          lasts[$];
  int          hs_times[$];
  logic [7:0]  exp_mem [DEPTH];
  bit          exp_wr [DEPTH];

  typedef struct {
    logic [31:0]     word;
    logic [0:3][7:0] exp_bytes;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_capture();
    epoch++;
    wbase_a = writes_a;
    wbase_b = writes_b;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    word_valid = 1'b0;
    last = 1'b0;
    step();
    step();
    check_output("rst_we", bus_a.we, 1'b0);
    check_output("rst_ready", bus_a.word_ready, 1'b0);
    check_output("rst_busy", busy_a, 1'b0);
    check_output("rst_hold", hold_a, 1'b1);
    check_output("rst_done", done_a, 1'b0);
    check_output("rst_ovf", ovf_a, 1'b0);
    check_output("rst_count", count_a, 8'd0);
    rst_n = 1'b1;
    step();
  endtask

  // Word-level model: each accepted word occupies four consecutive bytes, MSB first.
  task automatic build_expect(input int base, output int exp_words, output bit exp_ovf);
    int a;
    a = base & ~3;
    exp_words = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_wr[i] = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        exp_mem[a+k] = words[i][31-8*k -: 8];
        exp_wr[a+k]  = 1'b1;
      end
      exp_words++;
      a += 4;
      if (lasts[i]) break;
      if (a == DEPTH) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_image(input string name, input bit use_b, input int base);
    int ew;
    bit eo;
    int bad;
    build_expect(base, ew, eo);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bit         got_wr;
      logic [7:0] got;
      got_wr = use_b ? (ep_b[i] == epoch) : (ep_a[i] == epoch);
      got    = use_b ? cap_b[i] : cap_a[i];
      if ((got_wr != exp_wr[i]) || (exp_wr[i] && (got !== exp_mem[i]))) bad++;
    end
    check_output({name, "_bad_bytes"}, bad, 0);
    check_output({name, "_word_count"}, use_b ? count_b : count_a, ew);
    check_output({name, "_overflow"}, use_b ? ovf_b : ovf_a, eo);
    check_output({name, "_done"}, use_b ? done_b : done_a, 1'b1);
    check_output({name, "_writes"}, use_b ? (writes_b - wbase_b) : (writes_a - wbase_a), 4 * ew);
  endtask

  // Offers words from the queue until dut_a reports done; gaps randomly drop word_valid.
  task automatic run_load(input bit gaps, input int budget, output int accepted);
    int cycles = 0;
    int idx = 0;
    bit hs;
    hs_times.delete();
    while (!done_a && (cycles < budget)) begin
      if ((idx < words.size()) && (!gaps || ($urandom_range(0, 2) != 0))) begin
        word_valid = 1'b1;
        word_in    = words[idx];
        last       = lasts[idx];
      end else begin
        word_valid = 1'b0;
        word_in    = $urandom;
        last       = 1'($urandom_range(0, 1));
      end
      hs = word_valid && bus_a.word_ready;
      step();
      cycles++;
      if (hs) begin
        idx++;
        hs_times.push_back(cycles);
      end
    end
    word_valid = 1'b0;
    last = 1'b0;
    accepted = idx;
    check_output("load_finished", done_a, 1'b1);
  endtask

  task automatic apply_stimulus(input vec_t vec, input int v);
    pulse_start();
    check_output($sformatf("vec%0d_ready", v), bus_a.word_ready, 1'b1);
    check_output($sformatf("vec%0d_hold", v), hold_a, 1'b1);
    word_valid = 1'b1;
    word_in = vec.word;
    last = 1'b1;
    step();
    word_valid = 1'b0;
    last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("vec%0d_we%0d", v, k), bus_a.we, 1'b1);
      check_output($sformatf("vec%0d_waddr%0d", v, k), bus_a.waddr, k);
      check_output($sformatf("vec%0d_wdata%0d", v, k), bus_a.wdata, vec.exp_bytes[k]);
      check_output($sformatf("vec%0d_ready%0d", v, k), bus_a.word_ready, 1'b0);
      step();
    end
    check_output($sformatf("vec%0d_we_end", v), bus_a.we, 1'b0);
    check_output($sformatf("vec%0d_done", v), done_a, 1'b1);
    check_output($sformatf("vec%0d_hold_end", v), hold_a, 1'b0);
    check_output($sformatf("vec%0d_busy_end", v), busy_a, 1'b0);
    check_output($sformatf("vec%0d_count", v), count_a, 8'd1);
    check_output($sformatf("vec%0d_ovf", v), ovf_a, 1'b0);
  endtask

  initial begin
    int acc;
    bit seen;
    int w0;

    vecs[0] = '{word: 32'h81C3E008, exp_bytes: {8'h81, 8'hC3, 8'hE0, 8'h08}};
    vecs[1] = '{word: 32'hDEADBEEF, exp_bytes: {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    vecs[2] = '{word: 32'h00000000, exp_bytes: {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{word: 32'hFFFFFFFF, exp_bytes: {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[4] = '{word: 32'h12345678, exp_bytes: {8'h12, 8'h34, 8'h56, 8'h78}};
    vecs[5] = '{word: 32'hA55A0FF0, exp_bytes: {8'hA5, 8'h5A, 8'h0F, 8'hF0}};

    $display("[TB] reset and single-word loads");
    apply_reset();
    for (int v = 0; v < 6; v++) apply_stimulus(vecs[v], v);

    $display("[TB] three back-to-back words");
    apply_reset();
    words = {32'h01000000, 32'h9DE3BFA0, 32'h81C7E008};
    lasts = {1'b0, 1'b0, 1'b1};
    clear_capture();
    pulse_start();
    run_load(1'b0, 100, acc);
    check_output("three_accepted", acc, 3);
    check_output("three_gap01", (hs_times.size() > 2) ? hs_times[1] - hs_times[0] : -1, 5);
    check_output("three_gap12", (hs_times.size() > 2) ? hs_times[2] - hs_times[1] : -1, 5);
    check_image("three", 1'b0, 0);

    $display("[TB] overflow with 130 words");
    words.delete();
    lasts.delete();
    for (int i = 0; i < 130; i++) begin
      words.push_back($urandom);
      lasts.push_back(1'b0);
    end
    clear_capture();
    pulse_start();
    run_load(1'b0, 1000, acc);
    check_output("ovf_accepted", acc, 128);
    check_output("ovf_last_waddr", last_waddr_a, 511);
    check_output("ovf_hold", hold_a, 1'b0);
    check_image("ovf", 1'b0, 0);
    word_valid = 1'b1;
    word_in = words[128];
    seen = 1'b0;
    w0 = writes_a;
    repeat (10) begin
      if (bus_a.word_ready) seen = 1'b1;
      step();
    end
    word_valid = 1'b0;
    check_output("ovf_ready_after", seen, 1'b0);
    check_output("ovf_no_extra_writes", writes_a - w0, 0);

    $display("[TB] reset during byte 2");
    clear_capture();
    pulse_start();
    word_valid = 1'b1;
    word_in = 32'h13579BDF;
    last = 1'b1;
    step();
    word_valid = 1'b0;
    last = 1'b0;
    step();
    step();
    check_output("mid_we_before", bus_a.we, 1'b1);
    check_output("mid_waddr_before", bus_a.waddr, 2);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_we_async", bus_a.we, 1'b0);
    check_output("mid_busy", busy_a, 1'b0);
    check_output("mid_ready", bus_a.word_ready, 1'b0);
    check_output("mid_hold", hold_a, 1'b1);
    check_output("mid_count", count_a, 8'd0);
    check_output("mid_done", done_a, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    words = {32'hCAFEF00D};
    lasts = {1'b1};
    clear_capture();
    pulse_start();
    run_load(1'b0, 50, acc);
    check_image("mid_fresh", 1'b0, 0);

    $display("[TB] unaligned base at top of memory");
    apply_reset();
    words = {32'hDEADBEEF};
    lasts = {1'b1};
    clear_capture();
    pulse_start();
    run_load(1'b0, 50, acc);
    check_image("top_b", 1'b1, BASE_B);
    check_output("top_b_last_waddr", last_waddr_b, 'h1FF);
    check_output("top_b_byte_1fc", cap_b['h1FC], 8'hDE);
    check_output("top_b_hold", hold_b, 1'b0);

    $display("[TB] start during WRITE and valid gap in ACCEPT");
    words = {32'h0BADF00D, 32'h600DCAFE};
    lasts = {1'b0, 1'b1};
    clear_capture();
    pulse_start();
    word_valid = 1'b1;
    word_in = words[0];
    last = 1'b0;
    step();
    word_valid = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    seen = 1'b0;
    repeat (10) begin
      if (!bus_a.word_ready || bus_a.we || !busy_a) seen = 1'b1;
      step();
    end
    check_output("gap_waiting_ok", seen, 1'b0);
    check_output("gap_count", count_a, 8'd1);
    word_valid = 1'b1;
    word_in = words[1];
    last = 1'b1;
    step();
    word_valid = 1'b0;
    last = 1'b0;
    repeat (4) step();
    check_image("gap", 1'b0, 0);

    $display("[TB] randomized streams");
    for (int it = 0; it < 8; it++) begin
      int n;
      int lastidx;
      n = $urandom_range(1, 10);
      lastidx = $urandom_range(0, n - 1);
      words.delete();
      lasts.delete();
      for (int i = 0; i < n; i++) begin
        words.push_back($urandom);
        lasts.push_back(i == lastidx);
      end
      clear_capture();
      pulse_start();
      run_load(1'b1, 400, acc);
      check_output($sformatf("rand%0d_accepted", it), acc, lastidx + 1);
      check_image($sformatf("rand%0d", it), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
